spram_responder: RTL and testbench
==================================

Name: spram_responder

Overview:
- Behavioural single-port synchronous RAM that answers the ram_en/ram_we/ram_addr/ram_wr_data/ram_rd_data request interface driven by the team's ram_rw-style access generators.
- Lets initiator blocks be simulated and synthesised without a vendor memory core.
- Adds:
  - a post-reset clearing sweep that runs until init_done,
  - a configurable read pipeline with a data-valid strobe,
  - write/read access counters for bring-up debug.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, word width.
- READ_LATENCY, 1, edges from a sampled read request to ram_rd_data/ram_rd_valid; legal values 1 or 2.
- WRITE_MODE, 0, read-port behaviour on a write: 0 = read-first, 1 = write-first, 2 = no-change.
- INIT_VAL, 0, value written to every word by the reset sweep.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ram_en  in  1  access request, sampled each edge.
- ram_we  in  1  1 = write, 0 = read; ignored when ram_en=0.
- ram_addr  in  ADDR_W  word address.
- ram_wr_data  in  DATA_W  write data.
- ram_rd_data  out  DATA_W  read data, registered.
- ram_rd_valid  out  1  one-cycle strobe; ram_rd_data is new this cycle.
- init_done  out  1  high once the clearing sweep has finished.
- wr_cnt  out  16  accepted writes, saturating.
- rd_cnt  out  16  accepted reads, saturating.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst; it applies at any clock edge where rst=1.
- Reset values: state=INIT, sweep pointer=0, ram_rd_data=0, ram_rd_valid=0, all pipeline valid bits=0, init_done=0, wr_cnt=0, rd_cnt=0.
- Array contents are not reset directly; the INIT sweep rewrites them.
- State machine: INIT -> READY.
  - INIT:
    - Each edge with rst=0 writes INIT_VAL to mem[ptr] and increments ptr.
    - The edge that writes address DEPTH-1 moves the state to READY and sets init_done=1.
    - init_done is high after edge number DEPTH following reset release (32 for ADDR_W=5).
    - All requests are ignored: no array write, no valid, no count.
  - READY: stays until rst.
- A request is accepted only when state=READY and ram_en=1.
- Accepted write (ram_we=1):
  - mem[ram_addr] <= ram_wr_data.
  - wr_cnt increments.
  - Read port behaviour depends on WRITE_MODE:
    - 0: issues a read of the old word; rd_cnt does not increment.
    - 1: issues a read that returns ram_wr_data.
    - 2: issues no read; ram_rd_data and ram_rd_valid stay quiet.
- Accepted read (ram_we=0): captures mem[ram_addr] and increments rd_cnt.
- Read pipeline:
  - READ_LATENCY=1: data and valid are registered at the accepting edge, so they are visible the cycle after the request.
  - READ_LATENCY=2: one extra output register stage; data and valid appear one cycle later.
  - Issue rate is one request per cycle with no bubbles; back-to-back reads give back-to-back valids.
  - When no read completes, ram_rd_data holds its last value and ram_rd_valid=0.
- ram_en=0: no access; the pipeline still drains in-flight reads.
- Counters:
  - 16-bit, saturate at 16'hFFFF; no wrap.
  - Updated at the accepting edge.
- Addresses:
  - No out-of-range case exists; every ADDR_W value is a valid word.
  - The sweep pointer does not wrap after INIT.
- Reset mid-operation:
  - In-flight reads are discarded; no valid is emitted for them.
  - Counters clear, init_done drops, and the sweep restarts at address 0, overwriting all prior data.
- Simultaneous rst and ram_en: rst wins and the request is dropped.

Test Plan:
- Reset sweep (ADDR_W=5, INIT_VAL=0): release rst, hold ram_en=1, ram_we=1, data 0xFF throughout INIT -> init_done rises after edge 32; wr_cnt=0; reads of addresses 0..31 all return 0x00.
- Write then read (LATENCY=1, MODE=0):
  - Write 0xA5 to addr 3, then read addr 3 on the next cycle -> ram_rd_data=0xA5 with ram_rd_valid high for one cycle, one cycle after the read request.
  - wr_cnt=1, rd_cnt=1.
- Write-mode checks: with addr 3 holding 0xA5, write 0x5A to addr 3:
  - MODE=0 -> valid with 0xA5.
  - MODE=1 -> valid with 0x5A.
  - MODE=2 -> no valid and ram_rd_data unchanged.
  - In all three modes a subsequent read returns 0x5A.
- Pipelined reads (LATENCY=2): preload addr n with n+0x10 for n=0..7, then issue 8 consecutive reads of addresses 0..7 -> 8 consecutive valids carrying 0x10..0x17, the first two cycles after the first request.
- Mid-operation reset:
  - Issue reads of addresses 1 and 2 and assert rst in the following cycle -> no ram_rd_valid appears; counters go to 0; init_done=0.
  - After 32 edges a read of any address returns INIT_VAL.
- Counter saturation: force wr_cnt to 16'hFFFE via 65534 writes, then issue 3 more -> wr_cnt holds 16'hFFFF; rd_cnt is unaffected.

Source files
------------

// File: rtl/spram_responder.sv
// -----------------------------------------------------------------------------
// spram_responder
//
// Behavioural single-port synchronous RAM that answers the ram_en / ram_we /
// ram_addr / ram_wr_data / ram_rd_data request interface used by the ram_rw
// style access generators. It replaces a vendor memory core so that initiator
// blocks can be simulated and synthesised on their own.
//
// After every reset the array is swept to INIT_VAL, one word per clock. While
// the sweep runs, requests are ignored. Once the sweep is finished, init_done
// is raised and requests are served. Reads go through a pipeline of 1 or 2
// register stages that carries a valid strobe. Accepted writes and reads are
// counted in saturating 16-bit counters, which help during bring-up.
//
// Ports:
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous active-high reset
//   ram_en        in   1       access request, sampled every edge
//   ram_we        in   1       1 = write, 0 = read (ignored when ram_en = 0)
//   ram_addr      in   ADDR_W  word address
//   ram_wr_data   in   DATA_W  write data
//   ram_rd_data   out  DATA_W  registered read data, holds between reads
//   ram_rd_valid  out  1       one-cycle strobe, ram_rd_data is new
//   init_done     out  1       clearing sweep finished
//   wr_cnt        out  16      accepted writes, saturating
//   rd_cnt        out  16      accepted reads, saturating
// -----------------------------------------------------------------------------
module spram_responder #(
    parameter int                ADDR_W       = 5,
    parameter int                DATA_W       = 8,
    parameter int                READ_LATENCY = 1,
    parameter int                WRITE_MODE   = 0,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    output logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rd_valid,
    output logic              init_done,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       wrCnt_q, wrCnt_d;
    logic [15:0]       rdCnt_q, rdCnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              memWe;
    logic [ADDR_W-1:0] memWAddr;
    logic [DATA_W-1:0] memWData;
    logic              rdIssue;
    logic [DATA_W-1:0] rdIssueData;

    logic              s1Valid_q, s2Valid_q;
    logic [DATA_W-1:0] s1Data_q, s2Data_q;

    // State register, sweep pointer and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            wrCnt_q <= '0;
            rdCnt_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrCnt_q <= wrCnt_d;
            rdCnt_q <= rdCnt_d;
        end
    end

    // Next-state logic and request decode. The sweep owns the write port while
    // in INIT. In READY, accepted requests drive the write port and the read
    // issue. Because the memory updates with a non-blocking assignment,
    // rdIssueData taken from mem_q here is the old word. That old word is
    // exactly what the read-first mode returns on a write.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wrCnt_d     = wrCnt_q;
        rdCnt_d     = rdCnt_q;
        memWe       = 1'b0;
        memWAddr    = ptr_q;
        memWData    = INIT_VAL;
        rdIssue     = 1'b0;
        rdIssueData = mem_q[ram_addr];

        case (state_q)
            ST_INIT: begin
                memWe = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                if (ram_en) begin
                    if (ram_we) begin
                        memWe    = 1'b1;
                        memWAddr = ram_addr;
                        memWData = ram_wr_data;
                        if (wrCnt_q != CNT_MAX) begin
                            wrCnt_d = wrCnt_q + 16'd1;
                        end
                        if (WRITE_MODE == 1) begin
                            rdIssue     = 1'b1;
                            rdIssueData = ram_wr_data;
                        end else if (WRITE_MODE == 0) begin
                            rdIssue = 1'b1;
                        end
                    end else begin
                        rdIssue = 1'b1;
                        if (rdCnt_q != CNT_MAX) begin
                            rdCnt_d = rdCnt_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Storage array. It has no reset of its own, because the sweep rewrites
    // every word. The write is blocked while rst is high, so a request that
    // arrives together with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && memWe) begin
            mem_q[memWAddr] <= memWData;
        end
    end

    // Read pipeline. Each data register loads only when its valid loads, so
    // the output holds its last value between reads. Reset clears every
    // valid bit, which discards reads that are still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            s2Valid_q <= 1'b0;
            s2Data_q  <= '0;
        end else begin
            s1Valid_q <= rdIssue;
            if (rdIssue) begin
                s1Data_q <= rdIssueData;
            end
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Data_q <= s1Data_q;
            end
        end
    end

    assign ram_rd_data  = (READ_LATENCY == 2) ? s2Data_q  : s1Data_q;
    assign ram_rd_valid = (READ_LATENCY == 2) ? s2Valid_q : s1Valid_q;
    assign init_done    = (state_q == ST_READY);
    assign wr_cnt       = wrCnt_q;
    assign rd_cnt       = rdCnt_q;

endmodule

// File: tb/tb_spram_responder.sv
// -----------------------------------------------------------------------------
// tb_spram_responder
//
// Drives four responders from one shared request stream:
//   dut 0: latency 1, read-first
//   dut 1: latency 1, write-first
//   dut 2: latency 1, no-change
//   dut 3: latency 2, read-first
// Each instance is compared against hand-computed expectations. Outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_spram_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ramEn;
    logic       ramWe;
    logic [4:0] ramAddr;
    logic [7:0] ramWrData;

    logic [7:0]  rdData   [4];
    logic        rdValid  [4];
    logic        initDone [4];
    logic [15:0] wrCnt    [4];
    logic [15:0] rdCnt    [4];

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        en;
        logic        we;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [2:0]  expValid;
        logic [7:0]  expData0;
        logic [7:0]  expData1;
        logic [7:0]  expData2;
        logic [15:0] expWr;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    spram_responder #(.ADDR_W(5), .DATA_W(8), .READ_LATENCY(1), .WRITE_MODE(0), .INIT_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr),
        .ram_wr_data(ramWrData), .ram_rd_data(rdData[0]), .ram_rd_valid(rdValid[0]),
        .init_done(initDone[0]), .wr_cnt(wrCnt[0]), .rd_cnt(rdCnt[0]));

    spram_responder #(.ADDR_W(5), .DATA_W(8), .READ_LATENCY(1), .WRITE_MODE(1), .INIT_VAL(8'h00)) dut1 (
        .clk(clk), .rst(rst), .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr),
        .ram_wr_data(ramWrData), .ram_rd_data(rdData[1]), .ram_rd_valid(rdValid[1]),
        .init_done(initDone[1]), .wr_cnt(wrCnt[1]), .rd_cnt(rdCnt[1]));

    spram_responder #(.ADDR_W(5), .DATA_W(8), .READ_LATENCY(1), .WRITE_MODE(2), .INIT_VAL(8'h00)) dut2 (
        .clk(clk), .rst(rst), .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr),
        .ram_wr_data(ramWrData), .ram_rd_data(rdData[2]), .ram_rd_valid(rdValid[2]),
        .init_done(initDone[2]), .wr_cnt(wrCnt[2]), .rd_cnt(rdCnt[2]));

    spram_responder #(.ADDR_W(5), .DATA_W(8), .READ_LATENCY(2), .WRITE_MODE(0), .INIT_VAL(8'h00)) dut3 (
        .clk(clk), .rst(rst), .ram_en(ramEn), .ram_we(ramWe), .ram_addr(ramAddr),
        .ram_wr_data(ramWrData), .ram_rd_data(rdData[3]), .ram_rd_valid(rdValid[3]),
        .init_done(initDone[3]), .wr_cnt(wrCnt[3]), .rd_cnt(rdCnt[3]));

    // Drive one request, let one rising edge pass, and leave the outputs
    // settled so that they can be sampled.
    task automatic applyStimulus(input logic en, input logic we,
                                 input logic [4:0] addr, input logic [7:0] wdata);
        ramEn     = en;
        ramWe     = we;
        ramAddr   = addr;
        ramWrData = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllDuts(input string name, input int which, input logic [31:0] expected);
        for (int d = 0; d < 4; d++) begin
            case (which)
                0: checkOutput($sformatf("%s[%0d]", name, d), 32'(rdValid[d]), expected);
                1: checkOutput($sformatf("%s[%0d]", name, d), 32'(rdData[d]), expected);
                2: checkOutput($sformatf("%s[%0d]", name, d), 32'(initDone[d]), expected);
                3: checkOutput($sformatf("%s[%0d]", name, d), 32'(wrCnt[d]), expected);
                default: checkOutput($sformatf("%s[%0d]", name, d), 32'(rdCnt[d]), expected);
            endcase
        end
    endtask

    task automatic resetAndSweep();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        rst = 1'b0;
        repeat (32) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    function automatic logic [7:0] rowData(input vec_t v, input int d);
        case (d)
            0:       return v.expData0;
            1:       return v.expData1;
            default: return v.expData2;
        endcase
    endfunction

    // The test runs as one sequence of phases: sweep, mid-operation reset,
    // vector table, pipelined reads, and counter saturation.
    initial begin
        logic       prevValid;
        logic [7:0] prevData;

        // {en, we, addr, wdata, valid{d2,d1,d0}, data d0, d1, d2, wr_cnt, rd_cnt}
        vecs[0] = '{1'b1, 1'b1, 5'd3,  8'hA5, 3'b011, 8'h00, 8'hA5, 8'h00, 16'd1, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 5'd3,  8'h00, 3'b111, 8'hA5, 8'hA5, 8'hA5, 16'd1, 16'd1};
        vecs[2] = '{1'b0, 1'b0, 5'd3,  8'h00, 3'b000, 8'hA5, 8'hA5, 8'hA5, 16'd1, 16'd1};
        vecs[3] = '{1'b1, 1'b1, 5'd3,  8'h5A, 3'b011, 8'hA5, 8'h5A, 8'hA5, 16'd2, 16'd1};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  8'h00, 3'b111, 8'h5A, 8'h5A, 8'h5A, 16'd2, 16'd2};
        vecs[5] = '{1'b0, 1'b1, 5'd7,  8'h77, 3'b000, 8'h5A, 8'h5A, 8'h5A, 16'd2, 16'd2};
        vecs[6] = '{1'b1, 1'b0, 5'd7,  8'h00, 3'b111, 8'h00, 8'h00, 8'h00, 16'd2, 16'd3};
        vecs[7] = '{1'b1, 1'b0, 5'd3,  8'h00, 3'b111, 8'h5A, 8'h5A, 8'h5A, 16'd2, 16'd4};
        vecs[8] = '{1'b1, 1'b1, 5'd31, 8'hC3, 3'b011, 8'h00, 8'hC3, 8'h5A, 16'd3, 16'd4};
        vecs[9] = '{1'b1, 1'b0, 5'd31, 8'h00, 3'b111, 8'hC3, 8'hC3, 8'hC3, 16'd3, 16'd5};

        rst       = 1'b1;
        ramEn     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = '0;
        ramWrData = '0;

        // Reset with a write request pending: the request must be dropped.
        $display("[TB] reset and clearing sweep");
        applyStimulus(1'b1, 1'b1, 5'd0, 8'hFF);
        applyStimulus(1'b1, 1'b1, 5'd0, 8'hFF);
        checkAllDuts("rstInitDone", 2, 0);
        checkAllDuts("rstValid",    0, 0);
        checkAllDuts("rstData",     1, 0);
        checkAllDuts("rstWrCnt",    3, 0);
        checkAllDuts("rstRdCnt",    4, 0);

        // Writes of 0xFF are presented during the whole sweep and must be ignored.
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, 1'b1, 5'(k - 1), 8'hFF);
            checkOutput("sweepInitDone", 32'(initDone[0]), (k == 32) ? 1 : 0);
            checkOutput("sweepValid",    32'(rdValid[1]), 0);
            checkOutput("sweepWrCnt",    32'(wrCnt[0]), 0);
        end
        checkAllDuts("sweepDone", 2, 1);

        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b1, 1'b0, 5'(a), 8'h00);
            checkOutput($sformatf("sweepRdValid@%0d", a), 32'(rdValid[0]), 1);
            checkOutput($sformatf("sweepRdData@%0d", a),  32'(rdData[0]), 32'h00);
        end
        checkOutput("sweepRdCnt", 32'(rdCnt[0]), 32);
        checkOutput("sweepWrCnt", 32'(wrCnt[0]), 0);

        // Reset lands while two reads are still in flight in dut 3.
        $display("[TB] mid-operation reset");
        applyStimulus(1'b1, 1'b1, 5'd5, 8'h99);
        applyStimulus(1'b1, 1'b0, 5'd1, 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd2, 8'h00);
        checkOutput("preRstWrCnt", 32'(wrCnt[0]), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd3, 8'h00);
        checkAllDuts("midRstValid",    0, 0);
        checkAllDuts("midRstInitDone", 2, 0);
        checkAllDuts("midRstWrCnt",    3, 0);
        checkAllDuts("midRstRdCnt",    4, 0);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkAllDuts("midRstValid2", 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
            checkOutput("reSweepValid", 32'(rdValid[3]), 0);
            checkOutput("reSweepInitDone", 32'(initDone[3]), (k == 32) ? 1 : 0);
        end
        checkOutput("reSweepRdCnt", 32'(rdCnt[0]), 0);
        applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
        checkOutput("reSweepRd5Valid", 32'(rdValid[0]), 1);
        checkOutput("reSweepRd5Data",  32'(rdData[0]), 32'h00);
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("reSweepRd5ValidL2", 32'(rdValid[3]), 1);
        checkOutput("reSweepRd5DataL2",  32'(rdData[3]), 32'h00);
        checkOutput("reSweepRdCnt1", 32'(rdCnt[3]), 1);

        // Vector table. The latency-2 instance repeats the read-first
        // expectation of the previous row.
        $display("[TB] vector table");
        resetAndSweep();
        prevValid = 1'b0;
        prevData  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            for (int d = 0; d < 3; d++) begin
                checkOutput($sformatf("vec%0dValid[%0d]", i, d), 32'(rdValid[d]), 32'(vecs[i].expValid[d]));
                checkOutput($sformatf("vec%0dData[%0d]", i, d),  32'(rdData[d]),  32'(rowData(vecs[i], d)));
            end
            checkOutput($sformatf("vec%0dValid[3]", i), 32'(rdValid[3]), 32'(prevValid));
            checkOutput($sformatf("vec%0dData[3]", i),  32'(rdData[3]),  32'(prevData));
            checkAllDuts($sformatf("vec%0dWrCnt", i), 3, 32'(vecs[i].expWr));
            checkAllDuts($sformatf("vec%0dRdCnt", i), 4, 32'(vecs[i].expRd));
            prevValid = vecs[i].expValid[0];
            prevData  = vecs[i].expData0;
        end

        // Back-to-back reads through both pipeline depths.
        $display("[TB] pipelined reads");
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b1, 1'b1, 5'(n), 8'(8'h10 + n));
        end
        for (int j = 0; j < 10; j++) begin
            if (j < 8) applyStimulus(1'b1, 1'b0, 5'(j), 8'h00);
            else       applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
            checkOutput($sformatf("pipeL1Valid@%0d", j), 32'(rdValid[0]), (j < 8) ? 1 : 0);
            checkOutput($sformatf("pipeL1Data@%0d", j),  32'(rdData[0]), (j < 8) ? 32'(8'h10 + j) : 32'h17);
            if (j >= 1) begin
                checkOutput($sformatf("pipeL2Valid@%0d", j), 32'(rdValid[3]), (j <= 8) ? 1 : 0);
                checkOutput($sformatf("pipeL2Data@%0d", j),  32'(rdData[3]), (j <= 8) ? 32'(8'h10 + j - 1) : 32'h17);
            end
        end

        // Saturation of the write counter.
        $display("[TB] counter saturation");
        resetAndSweep();
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i), 8'h3C);
        end
        checkAllDuts("satWrCntFFFE", 3, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i), 8'h3C);
            checkAllDuts($sformatf("satWrCnt+%0d", i + 1), 3, 32'hFFFF);
        end
        checkAllDuts("satRdCnt", 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
